platform_field: RTL

Platform generator and scroller for Doodle Fall. It owns the seven platform positions and power flags that the doodle vertical-motion logic reads, and consumes that logic's `power_signal` output. Platforms rise at a fixed rate and respawn at the bottom with LFSR-derived horizontal positions. A power landing triggers a timed double-speed boost. The block sits between the game clock divider and both the doodle physics and the VGA renderer.

---
 rtl/platform_field.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/platform_field.sv
// Platform generator and scroller: seven rising platforms that respawn at the bottom
// with LFSR-derived columns, plus a timed double-speed boost triggered by power landings.
module platform_field #(
  parameter int          TOP_Y       = 0,
  parameter int          BOTTOM_Y    = 480,
  parameter int          SCREEN_W    = 640,
  parameter int          PLAT_W      = 75,
  parameter int          BOOST_TICKS = 32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        platform_tick,
  input  logic        terminated,
  input  logic        power_signal,
  output logic [9:0]  p1_vpos,
  output logic [9:0]  p2_vpos,
  output logic [9:0]  p3_vpos,
  output logic [9:0]  p4_vpos,
  output logic [9:0]  p5_vpos,
  output logic [9:0]  p6_vpos,
  output logic [9:0]  p7_vpos,
  output logic [9:0]  p1_hpos,
  output logic [9:0]  p2_hpos,
  output logic [9:0]  p3_hpos,
  output logic [9:0]  p4_hpos,
  output logic [9:0]  p5_hpos,
  output logic [9:0]  p6_hpos,
  output logic [9:0]  p7_hpos,
  output logic [6:0]  is_power,
  output logic        boosting,
  output logic [15:0] respawn_count
);

  localparam int          CNT_W    = $clog2(BOOST_TICKS + 1);
  localparam logic [9:0]  TOP_V    = 10'(TOP_Y);
  localparam logic [9:0]  BOTTOM_V = 10'(BOTTOM_Y);
  localparam logic [9:0]  H_MAX    = 10'(SCREEN_W - PLAT_W);

  typedef enum logic [1:0] {RUN = 2'd0, BOOST = 2'd1, HALT = 2'd2} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] boost_cnt_reg;
  logic [15:0]      lfsr_reg;
  logic [15:0]      respawn_count_reg;
  logic [6:0]       power_reg;
  logic             power_prev_reg;

  logic [9:0]       speed;
  logic             scroll_en;
  logic             power_edge;
  logic [9:0]       respawn_h;
  logic             respawn_p;
  logic             lfsr_fb;
  logic [6:0]       respawn;
  logic [6:0]       power_next;
  logic [2:0]       respawn_num;
  logic [9:0]       vpos [7];
  logic [9:0]       hpos [7];

  assign speed      = (state_reg == BOOST) ? 10'd2 : 10'd1;
  assign scroll_en  = platform_tick && !terminated && (state_reg != HALT);
  assign power_edge = power_signal && !power_prev_reg;
  assign lfsr_fb    = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  // Columns past the right edge fold back by 512 so every platform fits on screen.
  assign respawn_h  = (lfsr_reg[9:0] <= H_MAX) ? lfsr_reg[9:0] : lfsr_reg[9:0] - 10'd512;
  assign respawn_p  = &lfsr_reg[15:13];

  always_comb begin
    respawn_num = 3'd0;
    for (int i = 0; i < 7; i++) begin
      respawn_num = respawn_num + 3'(respawn[i]);
    end
  end

  for (genvar gi = 0; gi < 7; gi++) begin : g_plat
    logic [9:0] vpos_reg;
    logic [9:0] hpos_reg;

    // Wrap test precedes the subtraction so the row never underflows.
    assign respawn[gi]    = vpos_reg < (TOP_V + speed);
    assign power_next[gi] = respawn[gi] ? respawn_p : power_reg[gi];
    assign vpos[gi]       = vpos_reg;
    assign hpos[gi]       = hpos_reg;

    always_ff @(posedge clk) begin
      if (!rst) begin
        vpos_reg <= 10'(60 * (gi + 1));
        hpos_reg <= 10'(40 + 80 * gi);
      end else if (scroll_en) begin
        if (respawn[gi]) begin
          vpos_reg <= BOTTOM_V;
          hpos_reg <= respawn_h;
        end else begin
          vpos_reg <= vpos_reg - speed;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg         <= RUN;
      boost_cnt_reg     <= '0;
      lfsr_reg          <= LFSR_SEED;
      respawn_count_reg <= '0;
      power_reg         <= 7'b0001000;
      power_prev_reg    <= 1'b0;
    end else begin
      power_prev_reg <= power_signal;
      if (terminated) begin
        state_reg <= HALT;
      end else if (state_reg != HALT) begin
        if (platform_tick) begin
          power_reg         <= power_next;
          respawn_count_reg <= respawn_count_reg + 16'(respawn_num);
          if (|respawn) begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
          end
          if (state_reg == BOOST) begin
            boost_cnt_reg <= boost_cnt_reg - 1'b1;
            if (boost_cnt_reg == CNT_W'(1)) begin
              state_reg <= RUN;
            end
          end
        end
        // A power landing overrides the tick's effects on state, counter and flags.
        if (power_edge) begin
          state_reg     <= BOOST;
          boost_cnt_reg <= CNT_W'(BOOST_TICKS);
          power_reg     <= '0;
        end
      end
    end
  end

  assign p1_vpos       = vpos[0];
  assign p2_vpos       = vpos[1];
  assign p3_vpos       = vpos[2];
  assign p4_vpos       = vpos[3];
  assign p5_vpos       = vpos[4];
  assign p6_vpos       = vpos[5];
  assign p7_vpos       = vpos[6];
  assign p1_hpos       = hpos[0];
  assign p2_hpos       = hpos[1];
  assign p3_hpos       = hpos[2];
  assign p4_hpos       = hpos[3];
  assign p5_hpos       = hpos[4];
  assign p6_hpos       = hpos[5];
  assign p7_hpos       = hpos[6];
  assign is_power      = power_reg;
  assign boosting      = (state_reg == BOOST);
  assign respawn_count = respawn_count_reg;

endmodule
